button_debounce_encoder: RTL and testbench

//  Conditions the raw player push-buttons before the hit checker and game FSM.
//  Per button: 2-flop synchronizer, polarity fix, debounce state machine.

---
 rtl/button_debounce_encoder.sv | 149 ++++++++++++++
 tb/tb_button_debounce_encoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/button_debounce_encoder.sv
// Push-button conditioner: synchronizer, debounce FSM per button,
// one-cycle press pulses and an encoded press summary.
module button_debounce_encoder #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ID_W            = 2,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               enable,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic               press_valid,
    output logic [ID_W-1:0]    press_id,
    output logic               multi_press,
    output logic               any_down
);

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

    localparam logic             REL  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] s;

    db_state_t        state_q [NUM_BTN];
    db_state_t        state_d [NUM_BTN];
    logic [CNT_W-1:0] cnt_q   [NUM_BTN];
    logic [CNT_W-1:0] cnt_d   [NUM_BTN];

    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_d;
    logic [ID_W-1:0]    id_d;
    logic               multi_d;

    assign s = sync2_q ^ {NUM_BTN{REL}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {NUM_BTN{REL}};
            sync2_q <= {NUM_BTN{REL}};
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            press_d[i] = 1'b0;
            unique case (state_q[i])
                RELEASED: begin
                    if (s[i]) begin
                        state_d[i] = DB_PRESS;
                        cnt_d[i]   = '0;
                    end
                end
                DB_PRESS: begin
                    if (!s[i]) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == LAST) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        press_d[i] = enable;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s[i]) begin
                        state_d[i] = DB_RELEASE;
                        cnt_d[i]   = '0;
                    end
                end
                DB_RELEASE: begin
                    if (s[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == LAST) begin
                        state_d[i] = RELEASED;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == PRESSED) ||
                         (state_d[i] == DB_RELEASE);
        end
    end

    // Encoder works on the next-state press vector so it lines up with press_pulse
    always_comb begin
        int n;
        n    = 0;
        id_d = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press_d[i]) begin
                id_d = ID_W'(i);
                n    = n + 1;
            end
        end
        multi_d = (n > 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= RELEASED;
                cnt_q[i]   <= '0;
            end
            btn_level   <= '0;
            press_pulse <= '0;
            press_valid <= 1'b0;
            press_id    <= '0;
            multi_press <= 1'b0;
            any_down    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            btn_level   <= level_d;
            press_pulse <= press_d;
            press_valid <= |press_d;
            press_id    <= id_d;
            multi_press <= multi_d;
            any_down    <= |level_d;
        end
    end

endmodule

// File: tb/tb_button_debounce_encoder.sv
// Random stimulus bench for button_debounce_encoder against a
// run-length reference model of the debounce rules.
module tb_button_debounce_encoder;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  btn_raw;
    logic          enable;
    logic [N-1:0]  btn_level;
    logic [N-1:0]  press_pulse;
    logic          press_valid;
    logic [IW-1:0] press_id;
    logic          multi_press;
    logic          any_down;

    button_debounce_encoder #(
        .NUM_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(3),
        .ID_W(IW), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .enable(enable),
        .btn_level(btn_level), .press_pulse(press_pulse),
        .press_valid(press_valid), .press_id(press_id),
        .multi_press(multi_press), .any_down(any_down)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: pins pass through two delay stages, and a
    // button's level flips once the synced input has disagreed with
    // it for D+1 consecutive samples.
    logic [N-1:0]  m_p1, m_p2, m_level, m_pulse;
    logic          m_valid, m_multi, m_any;
    logic [IW-1:0] m_id;
    int            m_run [N];

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_level = '0; m_pulse = '0;
        m_valid = 0; m_multi = 0; m_any = 0; m_id = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic model_step(input logic [N-1:0] raw, input logic en,
                              input logic r);
        logic [N-1:0] pressed;
        if (r) begin
            model_reset();
            return;
        end
        pressed = m_p2;
        m_pulse = '0;
        for (int i = 0; i < N; i++) begin
            if (pressed[i] != m_level[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == D + 1) begin
                m_level[i] = ~m_level[i];
                m_run[i]   = 0;
                if (m_level[i] && en) m_pulse[i] = 1'b1;
            end
        end
        m_p2 = m_p1;
        m_p1 = ~raw;
        m_valid = |m_pulse;
        m_multi = $countones(m_pulse) > 1;
        m_id = '0;
        for (int i = N - 1; i >= 0; i--)
            if (m_pulse[i]) m_id = IW'(i);
        m_any = |m_level;
    endtask

    task automatic compare_all();
        check("btn_level", 32'(btn_level), 32'(m_level));
        check("press_pulse", 32'(press_pulse), 32'(m_pulse));
        check("press_valid", 32'(press_valid), 32'(m_valid));
        check("press_id", 32'(press_id), 32'(m_id));
        check("multi_press", 32'(multi_press), 32'(m_multi));
        check("any_down", 32'(any_down), 32'(m_any));
    endtask

    // One clock: compare at negedge, drive, then advance the model
    // over the coming posedge with the inputs just driven.
    task automatic cycle(input logic [N-1:0] raw, input logic en,
                         input logic r);
        @(negedge clk);
        compare_all();
        btn_raw = raw;
        enable  = en;
        rst     = r;
        model_step(raw, en, r);
    endtask

    int pulses_seen = 0;
    always @(negedge clk)
        if (!rst && press_valid) pulses_seen++;

    initial begin
        logic [N-1:0] raw;
        logic         en;
        int           hold;
        rst = 1'b1; btn_raw = '1; enable = 1'b1;
        model_reset();
        repeat (3) cycle('1, 1'b1, 1'b1);
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_pulse", 32'(press_pulse), 32'h0);
        repeat (3) cycle('1, 1'b1, 1'b0);

        // Directed: single press, bounce, simultaneous, enable-off
        repeat (12) cycle(4'b1110, 1'b1, 1'b0);
        repeat (2) cycle(4'b1010, 1'b1, 1'b0);
        cycle(4'b1110, 1'b1, 1'b0);
        repeat (12) cycle(4'b1010, 1'b1, 1'b0);
        repeat (12) cycle(4'b1111, 1'b1, 1'b0);
        repeat (12) cycle(4'b0101, 1'b1, 1'b0);
        repeat (12) cycle(4'b1111, 1'b1, 1'b0);
        repeat (8) cycle(4'b1110, 1'b0, 1'b0);
        repeat (8) cycle(4'b1110, 1'b1, 1'b0);
        repeat (12) cycle(4'b1111, 1'b1, 1'b0);
        // Reset mid-debounce with button still held
        repeat (5) cycle(4'b1101, 1'b1, 1'b0);
        cycle(4'b1101, 1'b1, 1'b1);
        repeat (12) cycle(4'b1101, 1'b1, 1'b0);

        // Random: per-bit toggles, fast then slow
        raw = btn_raw;
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 1500; c++) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(ph ? 29 : 6, 0) == 0)
                        raw[i] = ~raw[i];
                en = ($urandom_range(3, 0) != 0);
                cycle(raw, en, $urandom_range(299, 0) == 0);
            end
        end

        // Random whole-pattern steps to provoke simultaneous presses
        for (int c = 0; c < 80; c++) begin
            raw  = 4'($urandom);
            hold = $urandom_range(12, 1);
            en   = ($urandom_range(4, 0) != 0);
            repeat (hold) cycle(raw, en, 1'b0);
        end
        repeat (12) cycle('1, 1'b1, 1'b0);
        cycle('1, 1'b1, 1'b0);
        check("any_down_idle", 32'(any_down), 32'h0);
        if (pulses_seen == 0)
            check("pulses_observed", 32'(pulses_seen), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
